// File: rtl/ysyx_22040125_fwd_scoreboard.sv
// ysyx_22040125_fwd_scoreboard: bypass select and hazard stall for the ID instruction, with a long-op busy scoreboard.
// Optional stall counter and stall cause outputs: define YSYX_22040125_FWD_STALL_CNT_EN.
module ysyx_22040125_fwd_scoreboard #(
    parameter int NSRC  = 3,
    parameter int DEPTH = 3,
    parameter int REGW  = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      id_valid,
    input  logic [NSRC*REGW-1:0]      id_rs,
    input  logic [NSRC-1:0]           id_rs_used,
    input  logic [REGW-1:0]           id_rd,
    input  logic                      id_wen,
    input  logic                      id_is_load,
    input  logic                      id_is_long,
    input  logic                      pipe_adv,
    input  logic                      flush,
    input  logic                      long_done,
    input  logic [REGW-1:0]           long_rd,
    output logic [NSRC*(DEPTH+1)-1:0] fwd_sel,
    output logic                      stall
`ifdef YSYX_22040125_FWD_STALL_CNT_EN
    ,
    output logic [31:0]               stall_cnt,
    output logic [1:0]                stall_cause
`endif
);
    localparam int NREG = 2 ** REGW;

    logic [DEPTH:1]  s_valid, s_wen, s_load;
    logic [REGW-1:0] s_rd [1:DEPTH];
    logic [NREG-1:0] busy;
    logic [NSRC-1:0] lu_v, raw_v;
    logic            lu, raw, waw, st, take, issue;

    // Scanning oldest to youngest lets the youngest matching writer win.
    function automatic logic [DEPTH:0] sel_of(input logic [REGW-1:0] rs, input logic hot);
        sel_of = {{DEPTH{1'b0}}, 1'b1};
        for (int k = DEPTH; k >= 1; k--)
            if (hot && s_valid[k] && s_wen[k] && s_rd[k] == rs)
                sel_of = {{DEPTH{1'b0}}, 1'b1} << k;
    endfunction

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        logic [REGW-1:0] rs;
        logic            hot;
        assign rs       = id_rs[i*REGW +: REGW];
        assign hot      = id_rs_used[i] && rs != '0;
        assign fwd_sel[i*(DEPTH+1) +: DEPTH+1] = sel_of(rs, hot);
        assign lu_v[i]  = hot && s_valid[1] && s_load[1] && s_rd[1] == rs;
        assign raw_v[i] = hot && busy[rs];
    end

    assign lu    = |lu_v;
    assign raw   = |raw_v;
    assign waw   = id_wen && id_rd != '0 && busy[id_rd];
    assign st    = id_is_long && |busy;
    assign stall = id_valid && !flush && (lu || raw || waw || st);
    assign take  = id_valid && !flush && !stall;
    assign issue = take && pipe_adv && id_is_long && id_wen && id_rd != '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_valid <= '0;
            s_wen   <= '0;
            s_load  <= '0;
            for (int k = 1; k <= DEPTH; k++) s_rd[k] <= '0;
        end else if (pipe_adv) begin
            s_valid[1] <= take;
            s_wen[1]   <= take && id_wen && !id_is_long && id_rd != '0;
            s_load[1]  <= take && id_is_load;
            s_rd[1]    <= id_rd;
            for (int k = 2; k <= DEPTH; k++) begin
                s_valid[k] <= s_valid[k-1];
                s_wen[k]   <= s_wen[k-1];
                s_load[k]  <= s_load[k-1];
                s_rd[k]    <= s_rd[k-1];
            end
        end
    end

    // Issue is written after the clear so a same-index set wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            if (long_done) busy[long_rd] <= 1'b0;
            if (issue) busy[id_rd] <= 1'b1;
        end
    end

`ifdef YSYX_22040125_FWD_STALL_CNT_EN
    logic [1:0] cause;
    assign cause = !stall ? 2'd0 : lu ? 2'd1 : (raw || waw) ? 2'd2 : 2'd3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt   <= '0;
            stall_cause <= '0;
        end else begin
            if (stall && id_valid && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
            stall_cause <= cause;
        end
    end
`endif
endmodule

// File: tb/tb_ysyx_22040125_fwd_scoreboard.sv
// tb_ysyx_22040125_fwd_scoreboard: directed per-cycle vectors plus reset and set-vs-clear sequences.
module tb_ysyx_22040125_fwd_scoreboard;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_valid = 1'b0;
    logic [14:0] id_rs = '0;
    logic [2:0]  id_rs_used = '0;
    logic [4:0]  id_rd = '0;
    logic        id_wen = 1'b0, id_is_load = 1'b0, id_is_long = 1'b0;
    logic        pipe_adv = 1'b0, flush = 1'b0, long_done = 1'b0;
    logic [4:0]  long_rd = '0;
    logic [11:0] fwd_sel;
    logic        stall;
`ifdef YSYX_22040125_FWD_STALL_CNT_EN
    logic [31:0] stall_cnt;
    logic [1:0]  stall_cause;
`endif
    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        int v, rs0, rs1, rs2, used, rd, wen, ld, lg, adv, fl, ldn, lrd, e0, e1, e2, st;
    } vec_t;

    vec_t tbl[30];
    vec_t h;

    ysyx_22040125_fwd_scoreboard dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
        .id_rd(id_rd), .id_wen(id_wen), .id_is_load(id_is_load), .id_is_long(id_is_long),
        .pipe_adv(pipe_adv), .flush(flush), .long_done(long_done), .long_rd(long_rd),
        .fwd_sel(fwd_sel), .stall(stall)
`ifdef YSYX_22040125_FWD_STALL_CNT_EN
        , .stall_cnt(stall_cnt), .stall_cause(stall_cause)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        id_valid   = t.v[0];
        id_rs      = {t.rs2[4:0], t.rs1[4:0], t.rs0[4:0]};
        id_rs_used = t.used[2:0];
        id_rd      = t.rd[4:0];
        id_wen     = t.wen[0];
        id_is_load = t.ld[0];
        id_is_long = t.lg[0];
        pipe_adv   = t.adv[0];
        flush      = t.fl[0];
        long_done  = t.ldn[0];
        long_rd    = t.lrd[4:0];
    endtask

    task automatic apply(input vec_t t, input string nm);
        @(negedge clk);
        drive(t);
        #1;
        chk({nm, " fwd_sel"}, {20'd0, fwd_sel}, {20'd0, t.e2[3:0], t.e1[3:0], t.e0[3:0]});
        chk({nm, " stall"}, {31'd0, stall}, {31'd0, t.st[0]});
    endtask

    initial begin
        //          v rs0 rs1 rs2 used rd wen ld lg adv fl ldn lrd e0 e1 e2 st
        tbl[0]  = '{1, 0, 0, 0, 0, 5, 1, 0, 0, 1, 0, 0, 0, 1, 1, 1, 0};
        tbl[1]  = '{1, 5, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 1, 0};
        tbl[2]  = '{1, 5, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 2, 1, 1, 0};
        tbl[3]  = '{1, 5, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 4, 1, 1, 0};
        tbl[4]  = '{1, 5, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 8, 1, 1, 0};
        tbl[5]  = '{1, 5, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 1, 0};
        tbl[6]  = '{1, 0, 0, 0, 0, 7, 1, 0, 0, 1, 0, 0, 0, 1, 1, 1, 0};
        tbl[7]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 1, 0};
        tbl[8]  = '{1, 0, 0, 0, 0, 7, 1, 0, 0, 1, 0, 0, 0, 1, 1, 1, 0};
        tbl[9]  = '{1, 7, 0, 7, 3, 0, 0, 0, 0, 1, 0, 0, 0, 2, 1, 1, 0};
        tbl[10] = '{1, 0, 0, 0, 0, 9, 1, 1, 0, 1, 0, 0, 0, 1, 1, 1, 0};
        tbl[11] = '{1, 0, 9, 0, 2, 0, 0, 0, 0, 1, 0, 0, 0, 1, 2, 1, 1};
        tbl[12] = '{1, 0, 9, 0, 2, 0, 0, 0, 0, 1, 0, 0, 0, 1, 4, 1, 0};
        tbl[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 1, 0};
        tbl[14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 1, 0};
        tbl[15] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 1, 0};
        tbl[16] = '{1, 0, 0, 0, 0, 3, 1, 0, 1, 1, 0, 0, 0, 1, 1, 1, 0};
        tbl[17] = '{1, 3, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 1, 1};
        tbl[18] = '{1, 3, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 3, 1, 1, 1, 1};
        tbl[19] = '{1, 3, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 1, 0};
        tbl[20] = '{1, 0, 0, 0, 0, 3, 1, 0, 1, 1, 0, 0, 0, 1, 1, 1, 0};
        tbl[21] = '{1, 0, 0, 0, 0, 4, 1, 0, 1, 1, 0, 0, 0, 1, 1, 1, 1};
        tbl[22] = '{1, 0, 0, 0, 0, 3, 1, 0, 0, 1, 0, 0, 0, 1, 1, 1, 1};
        tbl[23] = '{1, 0, 0, 0, 0, 6, 1, 0, 0, 1, 0, 0, 0, 1, 1, 1, 0};
        tbl[24] = '{1, 0, 0, 0, 0, 9, 1, 1, 0, 1, 0, 0, 0, 1, 1, 1, 0};
        tbl[25] = '{1, 0, 9, 0, 2, 0, 0, 0, 0, 1, 1, 0, 0, 1, 2, 1, 0};
        tbl[26] = '{1, 0, 9, 0, 2, 0, 0, 0, 0, 1, 0, 0, 0, 1, 4, 1, 0};
        tbl[27] = '{1, 3, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 1, 1};
        tbl[28] = '{1, 3, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 1, 1, 1, 0};
        tbl[29] = '{0, 3, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 1, 0};

        h = '{1, 5, 5, 5, 7, 5, 1, 0, 1, 1, 0, 0, 0, 1, 1, 1, 0};
        drive(h);
        #3;
        chk("reset fwd_sel", {20'd0, fwd_sel}, 32'h111);
        chk("reset stall", {31'd0, stall}, 32'd0);
`ifdef YSYX_22040125_FWD_STALL_CNT_EN
        chk("reset stall_cnt", stall_cnt, 32'd0);
`endif
        repeat (2) @(negedge clk);
        h = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0};
        drive(h);
        rst = 1'b0;

        for (int r = 0; r < 30; r++) apply(tbl[r], $sformatf("row%0d", r));

        apply('{1, 0, 0, 0, 0, 8, 1, 0, 0, 1, 0, 0, 0, 1, 1, 1, 0}, "rst_pre_w8");
        apply('{1, 8, 3, 0, 3, 0, 0, 0, 0, 1, 0, 0, 0, 2, 1, 1, 1}, "rst_pre_rd");
        #2 rst = 1'b1;
        #1;
        chk("async_rst fwd_sel", {20'd0, fwd_sel}, 32'h111);
        chk("async_rst stall", {31'd0, stall}, 32'd0);
`ifdef YSYX_22040125_FWD_STALL_CNT_EN
        chk("async_rst stall_cnt", stall_cnt, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        apply('{1, 8, 3, 0, 3, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 1, 0}, "post_rst");

        apply('{1, 0, 0, 0, 0, 5, 1, 0, 1, 1, 0, 1, 5, 1, 1, 1, 0}, "setclr_issue");
        apply('{1, 5, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 1, 1}, "setclr_busy");
        apply('{1, 5, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 5, 1, 1, 1, 1}, "done_nobypass");
        apply('{1, 5, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 1, 0}, "done_release");
        apply('{1, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 1, 1, 1, 0}, "mul_x0");
        apply('{1, 0, 0, 0, 0, 4, 1, 0, 1, 1, 0, 0, 0, 1, 1, 1, 0}, "x0_not_busy");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ysyx_22040125_fwd_scoreboard.md
Name: ysyx_22040125_fwd_scoreboard

Overview:
- Parametrised forwarding and hazard unit for the in-order core. Evaluated against the instruction in ID.
- Tracks in-flight register writers in an internal DEPTH-stage shadow pipeline (EXE..WB).
- Keeps a per-register busy scoreboard for long-latency mul/div results.
- Produces one-hot bypass selects for NSRC source operands, plus a single stall covering load-use, long-op RAW/WAW and the long-unit structural hazard.

Parameters:
NSRC, 3, number of source operands checked (rs1, rs2, branch/jalr base)
DEPTH, 3, number of tracked post-ID stages (1=EXE, 2=MEM, 3=WB)
REGW, 5, register index width; scoreboard has 2**REGW entries

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-high reset
id_valid  in  1  ID holds a valid instruction
id_rs  in  NSRC*REGW  packed source indices, source i at [i*REGW +: REGW]
id_rs_used  in  NSRC  source i is actually read
id_rd  in  REGW  destination of ID instruction
id_wen  in  1  ID instruction writes id_rd
id_is_load  in  1  ID instruction is a load (result ready at end of stage 2)
id_is_long  in  1  ID instruction goes to the long unit (result via long_done)
pipe_adv  in  1  pipeline advances this cycle (no external/memory stall)
flush  in  1  ID instruction is killed (redirect resolved in EXE)
long_done  in  1  long unit writes back this cycle
long_rd  in  REGW  destination of the long-unit writeback
fwd_sel  out  NSRC*(DEPTH+1)  per-source one-hot: bit0=regfile, bit k=stage k result
stall  out  1  hold PC/IF/ID and insert a bubble into EXE

Behaviour:
- Clock and reset: one clock clk. Reset rst is asynchronous and active-high.
- Reset state: all shadow stages invalid; busy[] all zero. In reset, fwd_sel = bit0 for every source and stall = 0.
- Shadow stage k holds valid, rd, wen and load bits. Stage 1 loads only when pipe_adv=1.
- Stage 1 load rule:
  - It receives the ID instruction only if id_valid && !flush && !stall.
  - Its wen is id_wen && !id_is_long && id_rd!=0.
  - Otherwise stage 1 receives a bubble (valid=0).
- Stage k+1 <= stage k when pipe_adv=1. The last stage drops out. When pipe_adv=0, all stages hold.
- fwd_sel for source i (combinational):
  - bit0 if !id_rs_used[i] or rs==0.
  - Otherwise one-hot of the smallest k with valid_k && wen_k && rd_k==rs (youngest wins).
  - bit0 if no stage matches.
- stall is 0 if !id_valid or flush. Otherwise it is the OR of:
  - (a) load-use: a used nonzero source matches stage 1 with load=1;
  - (b) RAW on long op: busy[rs] for a used nonzero source;
  - (c) WAW: id_wen && id_rd!=0 && busy[id_rd];
  - (d) structural: id_is_long && any busy bit set (single long unit).
- Stall has no latency: it is combinational. It releases on the cycle the hazard clears.
- Scoreboard:
  - Set busy[id_rd] on issue: id_valid && id_is_long && id_wen && id_rd!=0 && pipe_adv && !stall && !flush.
  - Clear busy[long_rd] when long_done=1, independent of pipe_adv.
  - Set and clear of the same index in one cycle: set wins.
- long_done is not bypassed: a source with busy=1 in the cycle of long_done still stalls. It proceeds the next cycle via the regfile (bit0).
- Register x0 is never set busy and never matched.
- A flush does not clear busy bits, because long ops are issued past EXE and are never squashed.
- Reset mid-operation: all state clears immediately (asynchronous). Any long_done arriving for a now-clear index is harmless.
- Width rules: all index compares are full REGW-bit equality. fwd_sel is always exactly one-hot per source.

Optional Feature:
- Macro YSYX_22040125_FWD_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt (32 bits). It increments by 1 each cycle stall=1 && id_valid.
  - It saturates at 32'hFFFF_FFFF and resets to 0.
  - Adds output stall_cause (2 bits), registered: 00 none, 01 load-use, 10 long RAW/WAW, 11 structural. The priority is that order.
- Undefined: the ports are absent and there is no counter logic.

Test Plan:
1. ADD x5 issued, next ID reads rs1=x5 with pipe_adv=1 each cycle -> fwd_sel[src0]=4'b0010. One cycle later, with rs1=x5 still in ID and stalled by external pipe_adv=0, it stays 4'b0010 because stages hold.
2. Writers to x7 sitting in stage 1 and stage 3 at the same time, ID reads x7 -> fwd_sel=4'b0010 (youngest). Reading x0 -> 4'b0001.
3. LW x9 in stage 1, ID reads rs2=x9 -> stall=1 for one cycle and stage 1 becomes a bubble. Next cycle stall=0 and fwd_sel[src1]=4'b0100.
4. MUL x3 issued (busy[3]=1); ID reads x3 -> stall held until long_done with long_rd=3. The cycle after, stall=0 and fwd_sel=4'b0001. A second MUL while busy → stall=1 (structural).
5. Load-use hazard with flush=1 in the same cycle -> stall=0. Stage 1 receives a bubble and busy[] is unchanged.
6. Assert rst asynchronously while busy[3]=1 and the stages are valid -> busy clears and fwd_sel=all 4'b0001 immediately, stall=0. Macro build: stall_cnt returns to 0.
